// File: rtl/lru_pkg.sv
// Shared types and the reference victim walk for the tree pseudo-LRU tracker.
// The tree is stored in heap order: node n has children 2n (bit 0) and 2n+1 (bit 1).
package lru_pkg;

    localparam int IDX_W   = 10;
    localparam int N_NODES = 2**IDX_W - 1;

    typedef logic [IDX_W-1:0] lru_idx_t;
    typedef logic [N_NODES:1] lru_tree_t;

    // Follow the LRU side from the root; each visited bit becomes the next victim bit, MSB first.
    function automatic lru_idx_t plru_walk(input lru_tree_t tree);
        lru_idx_t n;
        lru_idx_t v;
        n = lru_idx_t'(1);
        v = '0;
        for (int l = 0; l < IDX_W; l++) begin
            v = {v[IDX_W-2:0], tree[n]};
            n = {n[IDX_W-2:0], tree[n]};
        end
        return v;
    endfunction

endpackage

// File: rtl/lru_plru_walk_comb.sv
// Combinational victim walk over a full PLRU tree: one tree bit is read per level,
// and that bit both extends the victim index and steers the walk to the next node.
module plru_walk_comb
    import lru_pkg::*;
(
    input  logic [N_NODES:1] i_tree,
    output logic [IDX_W-1:0] o_victim
);

    logic [IDX_W-1:0] w_path [IDX_W];
    logic [IDX_W-1:0] w_bit;

    assign w_path[0] = lru_idx_t'(1);

    generate
        for (genvar gi = 0; gi < IDX_W; gi++) begin : g_level
            assign w_bit[IDX_W-1-gi] = i_tree[w_path[gi]];
            if (gi < IDX_W-1) begin : g_step
                assign w_path[gi+1] = {w_path[gi][IDX_W-2:0], w_bit[IDX_W-1-gi]};
            end
        end
    endgenerate

    assign o_victim = w_bit;

endmodule

// File: rtl/lru.sv
// Tree pseudo-LRU replacement tracker: hits touch idx_i, misses touch the current victim,
// and idx_o presents the victim of the updated tree one cycle after each request.
module lru
    import lru_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             hit_i,
    input  logic             valid_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [N_NODES:1] r_tree;
    logic [N_NODES:1] w_tree_next;
    logic [IDX_W-1:0] r_idx;
    logic             r_valid;
    logic [IDX_W-1:0] w_victim_pre;
    logic [IDX_W-1:0] w_victim_post;
    logic [IDX_W-1:0] w_touch_idx;
    logic [IDX_W-1:0] w_tpath [IDX_W];

    plru_walk_comb u_walk_pre (
        .i_tree   (r_tree),
        .o_victim (w_victim_pre)
    );

    plru_walk_comb u_walk_post (
        .i_tree   (w_tree_next),
        .o_victim (w_victim_post)
    );

    // A miss fills the entry the pre-update tree points at.
    assign w_touch_idx = hit_i ? idx_i : w_victim_pre;

    // w_tpath[d] is the heap index of the node touched at depth d.
    assign w_tpath[0] = lru_idx_t'(1);

    generate
        for (genvar gi = 1; gi < IDX_W; gi++) begin : g_tpath
            assign w_tpath[gi] = {w_tpath[gi-1][IDX_W-2:0], w_touch_idx[IDX_W-gi]};
        end

        // Each node compares against the single path node at its depth and points away from the touched side.
        for (genvar gi = 1; gi <= N_NODES; gi++) begin : g_node
            localparam int D = $clog2(gi + 1) - 1;
            assign w_tree_next[gi] = (valid_i && (w_tpath[D] == lru_idx_t'(gi)))
                                   ? ~w_touch_idx[IDX_W-1-D]
                                   : r_tree[gi];
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tree  <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= valid_i;
            if (valid_i) begin
                r_tree <= w_tree_next;
                r_idx  <= w_victim_post;
            end
        end
    end

    assign valid_o = r_valid;
    assign idx_o   = r_idx;

endmodule

// File: tb/tb_lru.sv
// Self-checking bench for the tree pseudo-LRU tracker: directed scenarios plus random traffic,
// compared each cycle against an array-based model of the replacement tree.
module tb_lru;
    import lru_pkg::*;

    logic             clk_i;
    logic             rst_ni;
    logic             hit_i;
    logic             valid_i;
    logic [IDX_W-1:0] idx_i;
    logic             valid_o;
    logic [IDX_W-1:0] idx_o;

    int n_checks;
    int n_fail;

    int       mtree [1:N_NODES];
    lru_idx_t exp_idx;
    logic     exp_valid;
    bit       seen [0:N_NODES];
    int       n_distinct;

    lru dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .hit_i   (hit_i),
        .valid_i (valid_i),
        .idx_i   (idx_i),
        .valid_o (valid_o),
        .idx_o   (idx_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic void model_reset();
        for (int n = 1; n <= N_NODES; n++) mtree[n] = 0;
    endfunction

    function automatic int model_walk();
        int n;
        int v;
        n = 1;
        v = 0;
        for (int l = IDX_W-1; l >= 0; l--) begin
            v = v * 2 + mtree[n];
            n = 2 * n + mtree[n];
        end
        return v;
    endfunction

    function automatic void model_touch(input int idx);
        int n;
        int b;
        n = 1;
        for (int l = IDX_W-1; l >= 0; l--) begin
            b = (idx >> l) & 1;
            mtree[n] = 1 - b;
            n = 2 * n + b;
        end
    endfunction

    function automatic lru_tree_t model_packed();
        lru_tree_t t;
        for (int n = 1; n <= N_NODES; n++) t[n] = (mtree[n] != 0);
        return t;
    endfunction

    task automatic check_outputs(input string tag);
        n_checks++;
        assert (valid_o === exp_valid) else begin
            n_fail++;
            $error("FAIL %s valid_o: got %0b expected %0b", tag, valid_o, exp_valid);
        end
        n_checks++;
        assert (idx_o === exp_idx) else begin
            n_fail++;
            $error("FAIL %s idx_o: got %0d expected %0d", tag, idx_o, exp_idx);
        end
    endtask

    // Called at a falling edge: drive one request, advance the model, check after the next rising edge.
    task automatic cycle(input bit v, input bit h, input int idx, input string tag);
        lru_idx_t walk_pkg;
        valid_i = v;
        hit_i   = h;
        idx_i   = lru_idx_t'(idx);
        if (v) begin
            model_touch(h ? idx : model_walk());
            exp_idx = lru_idx_t'(model_walk());
        end
        exp_valid = v;
        @(posedge clk_i);
        @(negedge clk_i);
        check_outputs(tag);
        walk_pkg = plru_walk(model_packed());
        n_checks++;
        assert (walk_pkg === exp_idx) else begin
            n_fail++;
            $error("FAIL %s plru_walk: got %0d expected %0d", tag, walk_pkg, exp_idx);
        end
    endtask

    task automatic check_const(input string tag, input lru_idx_t want);
        n_checks++;
        assert (idx_o === want) else begin
            n_fail++;
            $error("FAIL %s idx_o: got %0d expected %0d", tag, idx_o, want);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_ni    = 1'b0;
        hit_i     = 1'b0;
        valid_i   = 1'b0;
        idx_i     = '0;
        exp_idx   = '0;
        exp_valid = 1'b0;
        model_reset();

        // T1: reset state
        repeat (2) @(negedge clk_i);
        check_outputs("T1_reset");
        rst_ni = 1'b1;
        @(negedge clk_i);
        check_outputs("T1_idle_after_reset");

        // T2..T5: directed sequence
        cycle(1'b1, 1'b1, 0, "T2_hit0");
        check_const("T2_const", 10'd512);
        cycle(1'b1, 1'b1, 1, "T3_hit1");
        cycle(1'b1, 1'b1, 3, "T3_hit3");
        cycle(1'b1, 1'b1, 7, "T3_hit7");
        cycle(1'b1, 1'b1, 3, "T3_hit3b");
        check_const("T3_const", 10'd512);
        cycle(1'b1, 1'b0, 1000, "T4_miss");
        check_const("T4_const", 10'd256);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 5, "T5_idle");
        check_const("T5_const", 10'd256);

        // Random traffic including idle cycles and repeated hits
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, N_NODES)), "RAND");
        end

        // Asynchronous reset between clock edges
        #2 rst_ni = 1'b0;
        #1;
        model_reset();
        exp_idx   = '0;
        exp_valid = 1'b0;
        check_outputs("ARST_rand");
        @(negedge clk_i);
        rst_ni = 1'b1;

        // T6: 1024 misses from reset visit every index exactly once
        for (int i = 0; i <= N_NODES; i++) seen[i] = 1'b0;
        n_distinct = 0;
        seen[0] = 1'b1;
        n_distinct = 1;
        for (int i = 0; i <= N_NODES; i++) begin
            cycle(1'b1, 1'b0, int'($urandom_range(0, N_NODES)), "T6_miss");
            if (i < N_NODES) begin
                n_checks++;
                assert (seen[idx_o] === 1'b0) else begin
                    n_fail++;
                    $error("FAIL T6_distinct: got repeated %0d expected unvisited index", idx_o);
                end
                if (!seen[idx_o]) n_distinct++;
                seen[idx_o] = 1'b1;
            end
        end
        n_checks++;
        assert (n_distinct === N_NODES + 1) else begin
            n_fail++;
            $error("FAIL T6_coverage: got %0d expected %0d", n_distinct, N_NODES + 1);
        end

        // Reset mid-stream with requests still arriving
        valid_i = 1'b1;
        hit_i   = 1'b0;
        @(posedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        model_reset();
        exp_idx   = '0;
        exp_valid = 1'b0;
        check_outputs("T6_arst");
        @(negedge clk_i);
        check_outputs("T6_arst_hold");
        rst_ni = 1'b1;
        cycle(1'b1, 1'b1, 37, "POST_RST_hit");
        cycle(1'b1, 1'b0, 0, "POST_RST_miss");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
